mrv1_issue_tw_arb: RTL and testbench

MRV1_ISSUE_TW_ARB -- requirements
Module: mrv1_issue_tw_arb

---
 rtl/mrv1_pkg.sv | 15 +
 rtl/mrv1_rr_pick.sv | 28 ++
 rtl/mrv1_issue_tw_arb.sv | 130 +++++++++++++
 tb/tb_mrv1_issue_tw_arb.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mrv1_pkg.sv
// Shared definitions for the mrv1 issue path: policy mode encodings and thread-id type.
package mrv1_pkg;

  typedef enum logic [1:0] {
    ModeBatch  = 2'd0,
    ModeRr     = 2'd1,
    ModeGreedy = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  // Widest thread id supported by the mrv1 core; narrower configs use the low bits.
  localparam int unsigned TwidMaxW = 8;
  typedef logic [TwidMaxW-1:0] twid_t;

endpackage

// File: rtl/mrv1_rr_pick.sv
// Rotating-priority find-first: returns the first set request at or after start_i, with wrap.
module mrv1_rr_pick #(
  parameter int unsigned Width = 8,
  localparam int unsigned IdxW = $clog2(Width)
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  start_i,
  output logic             vld_o,
  output logic [IdxW-1:0]  idx_o
);

  logic [IdxW-1:0] pos;

  // Scan from farthest to nearest so the nearest hit is the final assignment.
  always_comb begin
    vld_o = 1'b0;
    idx_o = start_i;
    pos   = '0;
    for (int i = Width - 1; i >= 0; i--) begin
      pos = start_i + IdxW'(i);
      if (req_i[pos]) begin
        vld_o = 1'b1;
        idx_o = pos;
      end
    end
  end

endmodule

// File: rtl/mrv1_issue_tw_arb.sv
// Thread/warp issue arbiter with batch, round-robin and greedy policies behind a
// registered valid/ack offer.
module mrv1_issue_tw_arb
  import mrv1_pkg::*;
#(
  parameter int unsigned NUM_TW_P    = 8,
  parameter int unsigned MAX_BURST_P = 4,
  localparam int unsigned twid_width_lp = $clog2(NUM_TW_P)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic [NUM_TW_P-1:0]      tw_rdy_i,
  input  logic                     issue_ack_i,
  output logic                     issue_vld_o,
  output logic [twid_width_lp-1:0] issue_twid_o,
  output logic                     batch_empty_o
);

  localparam int unsigned BurstW = $clog2(MAX_BURST_P + 1);
  localparam logic [BurstW-1:0] MaxBurst = BurstW'(MAX_BURST_P);

  logic                     vld_q, vld_d;
  logic [twid_width_lp-1:0] twid_q, twid_d;
  logic [twid_width_lp-1:0] last_q, last_d;
  logic [NUM_TW_P-1:0]      batch_q, batch_d;
  logic [BurstW-1:0]        burst_q, burst_d;
  mode_e                    mode_q, mode_d;

  mode_e                    mode_in;
  logic                     load, mode_chg, greedy_hold;
  logic [NUM_TW_P-1:0]      batch_base, snap, snap_eff;
  logic [BurstW-1:0]        burst_base;
  logic [twid_width_lp-1:0] rr_start, rr_idx, lo_idx, cand;
  logic                     rr_vld, lo_vld, cand_vld;

  assign mode_in  = mode_e'(mode_i);
  assign load     = !vld_q || issue_ack_i;
  assign mode_chg = (mode_in != mode_q);

  // A policy switch discards the old batch snapshot and burst run.
  assign batch_base = mode_chg ? '0 : batch_q;
  assign burst_base = mode_chg ? '0 : burst_q;
  assign snap       = batch_base & tw_rdy_i;
  assign snap_eff   = (snap == '0) ? tw_rdy_i : snap;
  assign rr_start   = last_q + twid_width_lp'(1);

  // burst_q == 0 means no run in progress, so the first greedy pick goes through RR.
  assign greedy_hold = tw_rdy_i[last_q] && (burst_base != '0) && (burst_base < MaxBurst);

  mrv1_rr_pick #(
    .Width (NUM_TW_P)
  ) u_rr_pick (
    .req_i   (tw_rdy_i),
    .start_i (rr_start),
    .vld_o   (rr_vld),
    .idx_o   (rr_idx)
  );

  mrv1_rr_pick #(
    .Width (NUM_TW_P)
  ) u_lo_pick (
    .req_i   (snap_eff),
    .start_i ('0),
    .vld_o   (lo_vld),
    .idx_o   (lo_idx)
  );

  always_comb begin
    vld_d    = vld_q;
    twid_d   = twid_q;
    last_d   = last_q;
    batch_d  = batch_q;
    burst_d  = burst_q;
    mode_d   = mode_q;
    cand     = rr_idx;
    cand_vld = rr_vld;
    if (load) begin
      mode_d  = mode_in;
      batch_d = batch_base;
      burst_d = burst_base;
      case (mode_in)
        ModeBatch: begin
          cand     = lo_idx;
          cand_vld = lo_vld;
          batch_d  = snap_eff;
          if (lo_vld) batch_d[lo_idx] = 1'b0;
        end
        ModeGreedy: begin
          if (greedy_hold) begin
            cand     = last_q;
            cand_vld = 1'b1;
            burst_d  = burst_base + BurstW'(1);
          end else if (rr_vld) begin
            burst_d = BurstW'(1);
          end
        end
        default: ;
      endcase
      vld_d = cand_vld;
      if (cand_vld) begin
        twid_d = cand;
        last_d = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q   <= 1'b0;
      twid_q  <= '0;
      last_q  <= twid_width_lp'(NUM_TW_P - 1);
      batch_q <= '0;
      burst_q <= '0;
      mode_q  <= ModeBatch;
    end else begin
      vld_q   <= vld_d;
      twid_q  <= twid_d;
      last_q  <= last_d;
      batch_q <= batch_d;
      burst_q <= burst_d;
      mode_q  <= mode_d;
    end
  end

  assign issue_vld_o   = vld_q;
  assign issue_twid_o  = twid_q;
  assign batch_empty_o = (batch_q == '0);

endmodule

// File: tb/tb_mrv1_issue_tw_arb.sv
// Directed and randomized checks of mrv1_issue_tw_arb against a policy-level reference model.
module tb_mrv1_issue_tw_arb;

  localparam int N  = 8;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst, ack, vld, empty;
  logic [1:0] mode;
  logic [7:0] rdy;
  logic [2:0] twid;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  // Reference model state
  int       m_last, m_burst, m_mode, m_twid;
  bit       m_vld;
  bit [7:0] m_batch;

  always #5 clk = ~clk;

  mrv1_issue_tw_arb #(
    .NUM_TW_P    (N),
    .MAX_BURST_P (MB)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mode_i        (mode),
    .tw_rdy_i      (rdy),
    .issue_ack_i   (ack),
    .issue_vld_o   (vld),
    .issue_twid_o  (twid),
    .batch_empty_o (empty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp)
    else begin
      bad_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, compare outputs on the falling edge.
  task automatic step(input bit r, input int md, input bit [7:0] rq, input bit a);
    int       cand, bu;
    bit [7:0] bb, sn;
    rst  = r;
    mode = md[1:0];
    rdy  = rq;
    ack  = a;
    if (r) begin
      m_vld = 0; m_twid = 0; m_batch = 0; m_burst = 0; m_last = N - 1; m_mode = 0;
    end else if (!m_vld || a) begin
      bb   = (md != m_mode) ? 8'h00 : m_batch;
      bu   = (md != m_mode) ? 0 : m_burst;
      cand = -1;
      for (int k = 1; k <= N; k++)
        if (cand < 0 && rq[(m_last + k) % N]) cand = (m_last + k) % N;
      m_batch = bb;
      m_burst = bu;
      if (md == 0) begin
        sn = bb & rq;
        if (sn == 0) sn = rq;
        cand = -1;
        for (int k = N - 1; k >= 0; k--) if (sn[k]) cand = k;
        if (cand >= 0) sn[cand] = 1'b0;
        m_batch = sn;
      end else if (md == 2) begin
        if (bu > 0 && bu < MB && rq[m_last]) begin
          cand    = m_last;
          m_burst = bu + 1;
        end else if (cand >= 0) begin
          m_burst = 1;
        end
      end
      m_vld = (cand >= 0);
      if (cand >= 0) begin
        m_twid = cand;
        m_last = cand;
      end
      m_mode = md;
    end
    @(posedge clk);
    @(negedge clk);
    chk("vld", vld, m_vld);
    chk("twid", twid, m_twid);
    chk("batch_empty", empty, m_batch == 0);
  endtask

  int exp_rr[6]     = '{0, 2, 5, 7, 0, 2};
  int exp_greedy[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
  int exp_batch[6]  = '{1, 2, 3, 1, 2, 3};
  int rmode;

  initial begin
    rst = 1'b1; ack = 1'b0; mode = 2'd0; rdy = 8'h00;
    m_vld = 0; m_twid = 0; m_batch = 0; m_burst = 0; m_last = N - 1; m_mode = 0;
    @(negedge clk);

    // Reset state, with activity on the inputs
    step(1, 1, 8'hFF, 1);
    step(1, 2, 8'h3C, 0);
    chk("rst_vld", vld, 0);
    chk("rst_twid", twid, 0);
    chk("rst_empty", empty, 1);

    // Round-robin rotation over a sparse ready mask
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'b1010_0101, 1);
      chk("rr_seq", twid, exp_rr[i]);
    end

    // Greedy bursts of MB then rotate
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, 2, 8'hFF, 1);
      chk("greedy_seq", twid, exp_greedy[i]);
    end

    // Batch snapshot and refill
    step(1, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 8'b0000_1110, 1);
      chk("batch_seq", twid, exp_batch[i]);
      if (i == 2 || i == 5) chk("batch_empty_after_third", empty, 1);
    end

    // Held offer while the offered thread drops ready
    step(1, 0, 8'h00, 0);
    step(0, 1, 8'h08, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h00, 0);
      chk("hold_vld", vld, 1);
      chk("hold_twid", twid, 3);
    end
    // Mid-offer mode change does not disturb the offer
    step(0, 2, 8'hF0, 0);
    chk("hold_mode_twid", twid, 3);

    // Batch -> RR -> batch switching
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'hFF, 1);
    step(0, 0, 8'hFF, 1);
    chk("sw_batch1", twid, 1);
    step(0, 1, 8'hFF, 1);
    chk("sw_rr_twid", twid, 2);
    chk("sw_rr_empty", empty, 1);
    step(0, 0, 8'hFF, 1);
    chk("sw_batch_fresh", twid, 0);
    chk("sw_batch_empty", empty, 0);

    // Reset overrides a pending ack
    step(1, 1, 8'hFF, 1);
    chk("rst_ack_vld", vld, 0);
    step(0, 1, 8'hFF, 1);
    chk("post_rst_rr", twid, 0);

    // Ack with no candidate drops valid
    step(0, 1, 8'h00, 1);
    chk("no_cand_drop", vld, 0);

    // Randomized traffic against the model
    rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) rmode = $urandom_range(0, 3);
      step($urandom_range(0, 99) == 0, rmode,
           ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom & $urandom),
           $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
